// File: rtl/sr_seq_pkg.sv
// Shared types and helpers for the SR bank sequencer: FSM states and the
// per-cell S/R drive encoding.
package sr_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // {s, r} drive encodings; SET and RESET are never combined.
  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_SET   = 2'b10;
  localparam logic [1:0] SR_RESET = 2'b01;

  function automatic logic [1:0] sr_encode(input logic diff, input logic target);
    if (!diff) return SR_HOLD;
    return target ? SR_SET : SR_RESET;
  endfunction

endpackage

// File: rtl/sr_seq_timer.sv
// Loadable down-counter with zero flag; times both the drive pulse and the
// settle gap of the sequencer.
module sr_seq_timer
  import sr_seq_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state is always written with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sr_bank_sequencer.sv
// Drives a bank of SR cells toward a requested value, verifies the result on
// the Q feedback and re-drives failing bits up to MAX_RETRY times.
module sr_bank_sequencer
  import sr_seq_pkg::*;
#(
  parameter int N             = 4,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_RETRY     = 2,
  parameter int RW            = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [N-1:0]  req_target,
  input  logic [N-1:0]  req_mask,
  input  logic [N-1:0]  q_fb,
  output logic [N-1:0]  s_out,
  output logic [N-1:0]  r_out,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [RW-1:0] retries
);

  localparam int TMAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] PULSE_LOAD  = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? TW'(SETTLE_CYCLES - 1) : '0;
  localparam logic [RW-1:0] RETRY_LIM   = RW'(MAX_RETRY);

  state_t        state, state_nxt;
  logic [N-1:0]  tgt, tgt_nxt;
  logic [N-1:0]  msk, msk_nxt;
  logic [N-1:0]  s_nxt, r_nxt;
  logic          err_nxt;
  logic [RW-1:0] retries_nxt;

  logic [N-1:0]  burst_diff, burst_tgt, burst_s, burst_r;
  logic          tmr_load, tmr_zero;
  logic [TW-1:0] tmr_val;

  sr_seq_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Bits still wrong: from the live request at accept, from latched state in CHECK.
  always_comb begin
    if (state == IDLE) begin
      burst_diff = req_mask & (req_target ^ q_fb);
      burst_tgt  = req_target;
    end else begin
      burst_diff = msk & (tgt ^ q_fb);
      burst_tgt  = tgt;
    end
    for (int i = 0; i < N; i++) begin
      {burst_s[i], burst_r[i]} = sr_encode(burst_diff[i], burst_tgt[i]);
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    tgt_nxt     = tgt;
    msk_nxt     = msk;
    s_nxt       = s_out;
    r_nxt       = r_out;
    err_nxt     = err;
    retries_nxt = retries;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          tgt_nxt     = req_target;
          msk_nxt     = req_mask;
          err_nxt     = 1'b0;
          retries_nxt = '0;
          if (burst_diff == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = DRIVE;
            s_nxt     = burst_s;
            r_nxt     = burst_r;
            tmr_load  = 1'b1;
            tmr_val   = PULSE_LOAD;
          end
        end
      end
      DRIVE: begin
        if (tmr_zero) begin
          s_nxt = '0;
          r_nxt = '0;
          if (SETTLE_CYCLES > 0) begin
            state_nxt = SETTLE;
            tmr_load  = 1'b1;
            tmr_val   = SETTLE_LOAD;
          end else begin
            state_nxt = CHECK;
          end
        end
      end
      SETTLE: begin
        if (tmr_zero) state_nxt = CHECK;
      end
      CHECK: begin
        if (burst_diff == '0) begin
          state_nxt = DONE;
        end else if (retries < RETRY_LIM) begin
          retries_nxt = retries + RW'(1);
          state_nxt   = DRIVE;
          s_nxt       = burst_s;
          r_nxt       = burst_r;
          tmr_load    = 1'b1;
          tmr_val     = PULSE_LOAD;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tgt     <= '0;
      msk     <= '0;
      s_out   <= '0;
      r_out   <= '0;
      err     <= 1'b0;
      retries <= '0;
    end else begin
      state   <= state_nxt;
      tgt     <= tgt_nxt;
      msk     <= msk_nxt;
      s_out   <= s_nxt;
      r_out   <= r_nxt;
      err     <= err_nxt;
      retries <= retries_nxt;
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: doc/sr_bank_sequencer.md
Name: sr_bank_sequencer

Overview:
- Initiator for a bank of N clocked SR flip-flop cells. Accepts a target-value write request and generates the S/R stimulus each cell needs to reach its target.
- Verifies the result on the cells' Q feedback and retries failed bits.
- Sits between a control/register block (valid/ready request side) and an array of sr_flipflop instances (S/R drive side, Q readback).

Parameters:
N, 4, number of SR cells driven
PULSE_CYCLES, 2, cycles S/R held asserted per drive burst (>=1)
SETTLE_CYCLES, 1, idle cycles after a burst before Q is checked (>=0)
MAX_RETRY, 2, extra drive bursts allowed after first failed check (>=0)
RW, 2, width of retry counter (must hold MAX_RETRY)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_target  input  N  desired Q value per cell
req_mask  input  N  1 = cell participates; 0 = cell left untouched
q_fb  input  N  Q outputs of the SR cells
s_out  output  N  Set drive to cells
r_out  output  N  Reset drive to cells
busy  output  1  request in progress
done  output  1  one-cycle completion pulse
err  output  1  completion status, valid with done, held until next accept
retries  output  RW  retry bursts used by last request, held until next accept

Behaviour:
- Reset (async, immediate): s_out=0, r_out=0, req_ready=1, busy=0, done=0, err=0, retries=0. State is IDLE.
- States and transitions:
  - IDLE: req_ready=1. Handshake is req_valid&&req_ready at a rising edge (cycle 0). Latch target and mask. Compute diff = mask & (target ^ q_fb) from the cycle-0 q_fb. Clear err and retries. If diff==0, go to DONE; otherwise go to DRIVE.
  - DRIVE: s_out = diff & target and r_out = diff & ~target, both registered. Held for exactly PULSE_CYCLES cycles (cycles 1..P). Then go to SETTLE, or to CHECK if SETTLE_CYCLES=0.
  - SETTLE: s_out=r_out=0 for SETTLE_CYCLES cycles.
  - CHECK (one cycle): compute fail = mask & (target ^ q_fb).
    - fail==0: go to DONE with err=0.
    - fail!=0 and retry count < MAX_RETRY: increment retries, set diff=fail, go to DRIVE.
    - Otherwise: go to DONE with err=1.
  - DONE: done=1 for one cycle, then IDLE.
- Latency (single burst): done is high in cycle P+S+2. With P=2 and S=1, done is high in cycle 5. No-op request: done is high in cycle 1.
- busy=1 and req_ready=0 in every non-IDLE state.
- req_valid is ignored while busy. A request is never lost or queued; the requester holds it until ready.
- Invariant: (s_out & r_out)==0 every cycle. The forbidden S=R=1 combination is never generated.
- Unmasked bits, and bits already correct, see S=R=0 (hold) throughout.
- q_fb is sampled only at accept and in CHECK. Changes during DRIVE/SETTLE do not affect outputs.
- Reset mid-operation: drive is abandoned, outputs clear asynchronously, no done pulse is generated, and cell state is whatever the partial burst produced.
- Request accepted in the same cycle DONE exits: not possible. DONE has req_ready=0; the next accept is no earlier than the first IDLE cycle.

Decomposition:
- Package sr_seq_pkg holds:
  - the state enum (IDLE, DRIVE, SETTLE, CHECK, DONE);
  - the encoding constants;
  - a function computing {s,r} from (diff, target).
- Sub-module sr_seq_timer is a loadable down-counter with a zero flag, shared by the DRIVE and SETTLE phases.

Test Plan:
- Setup: N=4, P=2, S=1, MAX_RETRY=2. q_fb comes from four sr_flipflop cells.
- 1. Assert rst mid-clock -> all outputs 0 immediately, req_ready=1 and busy=0 after release.
- 2. From q=0000, request target=1010, mask=1111 -> s_out=1010 and r_out=0000 in cycles 1-2, both 0 in cycle 3, done=1 in cycle 5, err=0, retries=0, q_fb=1010.
- 3. From q=1111, request target=0000, mask=0011 -> r_out=0011 and s_out=0000 for 2 cycles, final q_fb=1100, err=0.
- 4. Request target equal to current q_fb (e.g. 0110, mask=1111) -> done in cycle 1, s_out/r_out never nonzero.
- 5. Cell 0 feedback forced 0, target=0001, mask=0001 -> three s_out=0001 bursts, done with err=1, retries=2.
- 6. rst pulsed during DRIVE -> s_out drops asynchronously, no done pulse, and a fresh request after release completes normally.
